// File: rtl/fp_pkg.sv
// Shared floating-point types: result status codes and an unpacked-operand
// record wide enough for any format up to double precision. Users of the
// record occupy the low EXP_W / MAN_W+1 bits of each field.
package fp_pkg;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_NAN = 2'b01,
        ST_INF = 2'b10,
        ST_NUL = 2'b11
    } fp_state_e;

    localparam int FP_EXP_MAX = 11;
    localparam int FP_SIG_MAX = 53;   // hidden bit + stored mantissa

    typedef struct packed {
        logic                  sign;
        logic [FP_EXP_MAX-1:0] exp;
        logic [FP_SIG_MAX-1:0] sig;
    } fp_unpk_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W+1)
) (
    input  logic [W-1:0]  in_bits,
    output logic [CW-1:0] cnt
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++)
            if (in_bits[i]) cnt = CW'(W-1-i);
    end

endmodule

// File: rtl/fp_add_sub_pipe.sv
// Pipelined floating-point adder/subtractor, 4 stages:
// unpack/classify/swap -> align -> add/normalise -> round/pack.
// Subnormals flush to zero. Define FP_ADD_RNE_EN for round-to-nearest-even;
// otherwise results truncate toward zero.
module fp_add_sub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    input  logic                       sub,
    input  logic                       arg_vld,
    output logic                       arg_rdy,
    output logic [EXP_W+MAN_W:0]       result,
    output logic [1:0]                 state,
    output logic                       res_vld,
    input  logic                       res_rdy
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SW     = MAN_W + 1;          // significand with hidden bit
    localparam int XW     = MAN_W + 4;          // plus guard, round, sticky
    localparam int STAGES = 4;

    typedef logic [EXP_W:0] exp_t;              // one spare bit for overflow

    logic [STAGES-1:0] vld_pipe;
    logic              en;

    // Whole pipeline advances only when the output slot can move.
    assign arg_rdy = !(res_vld && !res_rdy);
    assign en      = arg_rdy;
    assign res_vld = vld_pipe[STAGES-1];

    // Valid bits shift with the data; bubbles enter when arg_vld is low.
    always_ff @(posedge clk) begin
        if (rst)     vld_pipe <= '0;
        else if (en) vld_pipe <= {vld_pipe[STAGES-2:0], arg_vld};
    end

    // ---------------- stage 1: unpack / classify / swap ----------------
    function automatic fp_unpk_t unpack(input logic s, input logic [EXP_W-1:0] e,
                                        input logic [MAN_W-1:0] m);
        fp_unpk_t u;
        u = '0;
        u.sign = s;
        u.exp[EXP_W-1:0] = e;
        u.sig[SW-1:0] = (e == '0) ? '0 : {1'b1, m};
        return u;
    endfunction

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    fp_state_e        kind1;
    logic             ssign1;
    fp_unpk_t         ua, ub;

    assign {sa, ea, ma} = a;
    assign sb = b[W-1] ^ sub;                   // classify on effective B sign
    assign eb = b[W-2 -: EXP_W];
    assign mb = b[MAN_W-1:0];
    assign ua = unpack(sa, ea, ma);
    assign ub = unpack(sb, eb, mb);

    // Special-case classification; ST_OK means take the arithmetic path.
    always_comb begin
        a_nan  = (&ea) && (ma != '0);
        a_inf  = (&ea) && (ma == '0);
        a_zero = (ea == '0);
        b_nan  = (&eb) && (mb != '0);
        b_inf  = (&eb) && (mb == '0);
        b_zero = (eb == '0);
        kind1  = ST_OK;
        ssign1 = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            kind1 = ST_NAN;
        end else if (a_inf || b_inf) begin
            kind1  = ST_INF;
            ssign1 = a_inf ? sa : sb;
        end else if (a_zero && b_zero) begin
            kind1  = ST_NUL;
            ssign1 = sa & sb;                   // -0 only for (-0) + (-0)
        end
    end

    fp_unpk_t         s1_big, s1_sml;
    fp_state_e        s1_kind;
    logic             s1_ssign, s1_sub;
    logic [EXP_W-1:0] s1_diff;

    // Larger magnitude goes to s1_big so later subtraction never goes negative.
    always_ff @(posedge clk) begin
        if (en) begin
            if ({ea, ma} >= {eb, mb}) begin
                s1_big  <= ua;
                s1_sml  <= ub;
                s1_diff <= ea - eb;
            end else begin
                s1_big  <= ub;
                s1_sml  <= ua;
                s1_diff <= eb - ea;
            end
            s1_kind  <= kind1;
            s1_ssign <= ssign1;
            s1_sub   <= sa ^ sb;
        end
    end

    // ---------------- stage 2: align ----------------
    logic [XW-1:0]   sml_x, aligned;
    logic [2*XW-1:0] sh_wide;

    // Right-shift the smaller significand; shifted-out bits fold into sticky.
    always_comb begin
        sml_x   = {s1_sml.sig[SW-1:0], 3'b000};
        sh_wide = '0;
        if (32'(s1_diff) > 32'(XW-1)) begin
            aligned = {{(XW-1){1'b0}}, |sml_x};
        end else begin
            sh_wide = {sml_x, {XW{1'b0}}} >> s1_diff;
            aligned = sh_wide[2*XW-1:XW] | {{(XW-1){1'b0}}, |sh_wide[XW-1:0]};
        end
    end

    fp_state_e        s2_kind;
    logic             s2_ssign, s2_sign, s2_sub;
    logic [EXP_W-1:0] s2_exp;
    logic [XW-1:0]    s2_big_x, s2_sml_x;

    // Align stage register.
    always_ff @(posedge clk) begin
        if (en) begin
            s2_kind  <= s1_kind;
            s2_ssign <= s1_ssign;
            s2_sign  <= s1_big.sign;
            s2_sub   <= s1_sub;
            s2_exp   <= s1_big.exp[EXP_W-1:0];
            s2_big_x <= {s1_big.sig[SW-1:0], 3'b000};
            s2_sml_x <= aligned;
        end
    end

    // ---------------- stage 3: add / normalise ----------------
    logic [XW:0]             sum;
    logic [$clog2(XW+1)-1:0] lz;
    fp_state_e               kind3;
    logic                    sign3;
    exp_t                    exp3;
    logic [XW-1:0]           man3;

    fp_lzc #(.W(XW)) u_lzc (
        .in_bits (sum[XW-1:0]),
        .cnt     (lz)
    );

    // Add/subtract magnitudes, then renormalise right on carry or left by lz.
    always_comb begin
        sum   = s2_sub ? ({1'b0, s2_big_x} - {1'b0, s2_sml_x})
                       : ({1'b0, s2_big_x} + {1'b0, s2_sml_x});
        kind3 = s2_kind;
        sign3 = (s2_kind == ST_OK) ? s2_sign : s2_ssign;
        exp3  = {1'b0, s2_exp};
        man3  = sum[XW-1:0];
        if (s2_kind == ST_OK) begin
            if (sum == '0) begin
                kind3 = ST_NUL;                 // exact cancellation is +0
                sign3 = 1'b0;
            end else if (sum[XW]) begin
                exp3 = {1'b0, s2_exp} + exp_t'(1);
                man3 = {sum[XW:2], sum[1] | sum[0]};
            end else if ({1'b0, s2_exp} <= exp_t'(lz)) begin
                kind3 = ST_NUL;                 // would be subnormal: flush
                sign3 = 1'b0;
            end else begin
                exp3 = {1'b0, s2_exp} - exp_t'(lz);
                man3 = sum[XW-1:0] << lz;
            end
        end
    end

    fp_state_e     s3_kind;
    logic          s3_sign;
    exp_t          s3_exp;
    logic [XW-1:0] s3_man;

    // Normalise stage register.
    always_ff @(posedge clk) begin
        if (en) begin
            s3_kind <= kind3;
            s3_sign <= sign3;
            s3_exp  <= exp3;
            s3_man  <= man3;
        end
    end

    // ---------------- stage 4: round / pack ----------------
    logic [SW:0]      sig_r;
    exp_t             exp4;
    logic [MAN_W-1:0] man4;
    logic [W-1:0]     res_n;
    fp_state_e        st_n;

    // Round the normalised significand and build the final word and status.
    always_comb begin
        sig_r = {1'b0, s3_man[XW-1:3]};
`ifdef FP_ADD_RNE_EN
        if (s3_man[2] && (s3_man[1] || s3_man[0] || s3_man[3]))
            sig_r = sig_r + {{SW{1'b0}}, 1'b1};
`endif
        exp4 = s3_exp;
        man4 = sig_r[MAN_W-1:0];
        if (sig_r[SW]) begin                    // rounding carried out: renormalise
            exp4 = s3_exp + exp_t'(1);
            man4 = sig_r[MAN_W:1];
        end
        case (s3_kind)
            ST_NAN: begin
                res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                st_n  = ST_NAN;
            end
            ST_INF: begin
                res_n = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                st_n  = ST_INF;
            end
            ST_NUL: begin
                res_n = {s3_sign, {(W-1){1'b0}}};
                st_n  = ST_NUL;
            end
            default: begin
                if (exp4 >= exp_t'({EXP_W{1'b1}})) begin
                    res_n = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    st_n  = ST_INF;
                end else begin
                    res_n = {s3_sign, exp4[EXP_W-1:0], man4};
                    st_n  = ST_OK;
                end
            end
        endcase
    end

    // Output register; holds while stalled, only updated by a valid stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            state  <= '0;
        end else if (en && vld_pipe[STAGES-2]) begin
            result <= res_n;
            state  <= st_n;
        end
    end

    // Spare record bits and the low rounding bits are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{s1_big.exp[FP_EXP_MAX-1:EXP_W], s1_big.sig[FP_SIG_MAX-1:SW],
                           s1_sml.exp, s1_sml.sig[FP_SIG_MAX-1:SW], s1_sml.sign,
                           s3_man[2:0]};

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Scoreboard bench for fp_add_sub_pipe (single precision). Expected results
// are queued at issue; a monitor pops and compares on each output handshake.
module tb_fp_add_sub_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] a, b;
    logic        sub;
    logic        arg_vld;
    logic        arg_rdy;
    logic [31:0] result;
    logic [1:0]  state;
    logic        res_vld;
    logic        res_rdy;

    localparam logic [1:0] OK = 2'b00, NAN = 2'b01, INF = 2'b10, NUL = 2'b11;

    typedef struct packed {
        logic [31:0] r;
        logic [1:0]  st;
    } exp_rec_t;

    exp_rec_t sb_q[$];
    exp_rec_t mon_e;
    int       checks = 0;
    int       errors = 0;

    fp_add_sub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .sub     (sub),
        .arg_vld (arg_vld),
        .arg_rdy (arg_rdy),
        .result  (result),
        .state   (state),
        .res_vld (res_vld),
        .res_rdy (res_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every transferred result against the queue head.
    always @(negedge clk) begin
        if (!rst && res_vld && res_rdy) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h/%b with nothing outstanding", result, state);
            end else begin
                mon_e = sb_q.pop_front();
                checks++;
                if (result !== mon_e.r) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", result, mon_e.r);
                end
                checks++;
                if (state !== mon_e.st) begin
                    errors++;
                    $display("FAIL state: got %b expected %b (result %h)", state, mon_e.st, mon_e.r);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Present one operation and hold it until accepted; queue its expectation.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                         input logic [31:0] er, input logic [1:0] es);
        int n;
        a = ta; b = tb; sub = ts; arg_vld = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arg_rdy && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!arg_rdy) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: arg_rdy stayed %b, expected 1", arg_rdy);
        end else begin
            sb_q.push_back('{r: er, st: es});
        end
        @(posedge clk); #1;
        arg_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("drain_outstanding", 32'(sb_q.size()), 32'd0);
    endtask

    logic [31:0] ints [0:9] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
                               32'h41000000, 32'h41100000};

    initial begin
        int lat;
        logic [31:0] held;
        a = '0; b = '0; sub = 1'b0; arg_vld = 1'b0; res_rdy = 1'b1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_res_vld", 32'(res_vld), 32'd0);
        chk("reset_result", result, 32'h0);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_arg_rdy", 32'(arg_rdy), 32'd1);
        @(posedge clk); #1;

        // Latency: accepted op must appear on the 4th cycle.
        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, OK);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (res_vld) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd4);
        drain();

        // Directed special and boundary cases.
        issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, NUL);
        issue(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, NUL);
        issue(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, NAN);
        issue(32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, INF);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, INF);
        issue(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, NAN);
        issue(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, INF);
        issue(32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, OK);
        issue(32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, OK);
        issue(32'h00000001, 32'h00000001, 1'b0, 32'h00000000, NUL);
        issue(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, OK);
        issue(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, NUL);
        issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, OK);
`ifdef FP_ADD_RNE_EN
        issue(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, OK);
`else
        issue(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, OK);
`endif
        drain();

        // Back-to-back stream with a 3-cycle consumer stall.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    issue(ints[i+1], 32'h3F800000, 1'b0, ints[i+2], OK);
            end
            begin
                int n;
                n = 0;
                @(posedge clk); #1;
                while (!res_vld && n < 30) begin
                    n++;
                    @(posedge clk); #1;
                end
                chk("stall_first_vld", 32'(res_vld), 32'd1);
                res_rdy = 1'b0;
                held = result;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_arg_rdy", 32'(arg_rdy), 32'd0);
                    chk("stall_res_vld", 32'(res_vld), 32'd1);
                    chk("stall_result_hold", result, held);
                    @(posedge clk); #1;
                end
                res_rdy = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight discards them.
        issue(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, OK);
        issue(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, OK);
        issue(32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, OK);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_res_vld", 32'(res_vld), 32'd0);
        chk("midreset_arg_rdy", 32'(arg_rdy), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        issue(32'h40A00000, 32'h3F800000, 1'b0, 32'h40C00000, OK);
        drain();
        repeat (8) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
